// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin 8:1 mux arbiter with a registered valid/ready output stage.
// Define MUX8_ARB_BURST_LOCK_EN to hold the grant on one requester until its last beat.
module mux8_rr_arbiter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   req,
    input  logic [7:0]   last,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    input  logic [W-1:0] in4,
    input  logic [W-1:0] in5,
    input  logic [W-1:0] in6,
    input  logic [W-1:0] in7,
    output logic [7:0]   gnt,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic [2:0]   out_src,
    input  logic         out_ready
);
    logic [W-1:0] din [8];
    logic [2:0]   ptr, win, idx;
    logic         hit, free, take;

    assign din = '{in0, in1, in2, in3, in4, in5, in6, in7};

`ifdef MUX8_ARB_BURST_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t     state, state_d;
    logic [2:0] owner, owner_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= '0;
        end else begin
            state <= state_d;
            owner <= owner_d;
        end
    end

    always_comb begin
        state_d = state;
        owner_d = owner;
        if (take && state == IDLE && !last[win]) begin
            state_d = LOCKED;
            owner_d = win;
        end else if (take && state == LOCKED && last[win]) begin
            state_d = IDLE;
        end
    end
`endif

    // search starts one past the last winner, so ptr itself has lowest priority
    always_comb begin
        win = ptr;
        hit = 1'b0;
        idx = ptr;
        for (int k = 1; k <= 8; k++) begin
            idx = ptr + 3'(k);
            if (!hit && req[idx]) begin
                hit = 1'b1;
                win = idx;
            end
        end
`ifdef MUX8_ARB_BURST_LOCK_EN
        if (state == LOCKED) begin
            hit = req[owner];
            win = owner;
        end
`endif
    end

    assign free = !out_valid || out_ready;
    assign take = free && hit;
    assign gnt  = take ? 8'b1 << win : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
            ptr       <= 3'd7;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= din[win];
            out_last  <= last[win];
            out_src   <= win;
            ptr       <= win;
        end else if (free) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter that shares one 8:1 W-bit mux among eight requesters and registers the selected beat into a single-entry valid/ready output stage. It sits in front of the shared mux datapath, generates the select from the winning requester, and returns a one-hot grant to each source. Throughput is one beat per cycle while the sink is ready.

## Interface

- W, 8, data width of every input and of out_data
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous and active-low
- req  input  8  req[i]: requester i holds a valid beat on in_i
- last  input  8  last[i]: the beat on in_i ends requester i's burst
- in0..in7  input  W each  requester data
- gnt  output  8  one-hot or zero; gnt[i] means in_i is accepted this cycle
- out_valid  output  1  output register holds a beat
- out_data  output  W  registered selected data
- out_last  output  1  registered last of the accepted beat
- out_src  output  3  index of the requester that supplied out_data
- out_ready  input  1  sink accepts the output beat this cycle

## Operation

- Slot free = !out_valid || out_ready.
- Arbitration: when the slot is free, the winner is the first i with req[i]=1, searching ptr+1, ptr+2, … modulo 8, where ptr is the index of the last accepted requester. gnt has the winner's bit set; otherwise gnt=0. gnt never asserts for a requester with req=0.
- The winner index drives the mux select; on the clock edge the register loads out_data=in_winner, out_last=last[winner], out_src=winner, out_valid=1, and ptr=winner.
- Slot free with no req: out_valid clears if it was drained, and ptr is unchanged.
- out_valid=1 and out_ready=0: gnt=0, and all output registers hold.
- Requesters hold req, last and data stable until gnt. req must not depend combinationally on gnt.
- Arithmetic: ptr is 3 bits and wraps 7→0.
- Reset values: out_valid=0, out_data=0, out_last=0, out_src=0, ptr=7 (so requester 0 has first priority), state IDLE. Reset mid-burst drops the lock and discards any held beat.

## Timing

- gnt is combinational from req, state, ptr, out_valid and out_ready in the same cycle.
- Latency is 1 cycle from the gnt cycle to out_valid=1.
- A beat is accepted and a new beat is granted in the same cycle when out_valid && out_ready, giving back-to-back throughput.
- FSM (lock feature only):
  - IDLE: on a granted beat with last=0, go to LOCKED with owner=winner. With last=1, stay IDLE.
  - LOCKED: only the owner can be granted, and other req are ignored. A granted owner beat with last=1 returns the FSM to IDLE.
  - An owner with req=0 while LOCKED leaves gnt=0 and the state held.

## Configuration

- MUX8_ARB_BURST_LOCK_EN defined: the IDLE/LOCKED FSM is present, so a grant persists across a burst until the beat with last=1 is accepted.
- MUX8_ARB_BURST_LOCK_EN undefined: there is no FSM, every beat is re-arbitrated round-robin, and last is only passed to out_last.

## Test plan

- Reset then req=8'hFF, out_ready=1: gnt sequence is 01,02,04,…,80,01; out_src is 0..7 one cycle later, with out_valid high continuously.
- Single requester req=8'h20, in5=8'hA5, last[5]=1: gnt=8'h20 on every cycle; out_data=8'hA5 and out_src=5 one cycle after the first grant.
- Backpressure: out_valid=1 with out_ready=0 for 3 cycles and req=8'h03: gnt=0 and out_data holds. On release, the next grant follows ptr.
- Lock enabled, req=8'h09 with requester 0 sending beats last=0,0,1: three consecutive grants go to requester 0, then requester 3. With lock disabled, grants alternate 0,3,0.
- Async reset asserted mid-burst with out_valid=1: out_valid drops immediately, and after release the first grant goes to the lowest active index.
- req=0 after draining: out_valid falls to 0 after the last accepted beat, ptr is unchanged, and the next req=8'h80 is granted with 1-cycle latency.
